// File: rtl/elec_pkg.sv
// Shared types and constants for the electricity display: converter FSM states,
// 7-segment codes ({dp,g,f,e,d,c,b,a}, active-high) and the digit-to-segment decoder.
package elec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    localparam int unsigned BCD_W = 12;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] seg_of(input logic [3:0] digit);
        logic [7:0] code;
        code = SEG_BLANK;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, result clamped to 999.
// Exposes its FSM state so the parent can qualify start and checkers can bind to it.
module bin2bcd_seq
    import elec_pkg::*;
#(
    parameter int W = 10
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     din,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] result,
    output logic             ovf,
    output conv_state_t      state
);

    // Handshake: start is accepted only on a cycle where state==IDLE; din must then
    // stay stable until done, which is high for exactly the one DONE cycle while
    // result/ovf are valid. busy covers the whole LOAD..DONE span.

    localparam int SH_W = BCD_W + W;
    localparam logic [3:0] ITER_LAST = 4'(W - 1);

    conv_state_t     state_next;
    logic [SH_W-1:0] sh;
    logic [3:0]      iter;

    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] r;
        r = v;
        for (int n = 0; n < 3; n++) begin
            if (r[W+4*n +: 4] >= 4'd5) begin
                r[W+4*n +: 4] = r[W+4*n +: 4] + 4'd3;
            end
        end
        return {r[SH_W-2:0], 1'b0};
    endfunction

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (iter == ITER_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            sh   <= '0;
            iter <= '0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) busy <= 1'b1;
                end
                LOAD: begin
                    sh   <= {{BCD_W{1'b0}}, din};
                    iter <= '0;
                end
                SHIFT: begin
                    sh   <= dabble_step(sh);
                    iter <= iter + 4'd1;
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Values above 999 cannot be shown on three digits; saturate and flag instead.
    assign ovf    = (32'(din) > 32'd999);
    assign result = ovf ? 12'h999 : sh[SH_W-1:W];
    assign done   = (state == DONE);

endmodule

// File: rtl/elec_display.sv
// Shows the charged-electricity value on a 4-digit multiplexed 7-segment display,
// re-running the BCD conversion whenever the input differs from the last converted value.
module elec_display
    import elec_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int W        = 10
) (
    input  logic         clkin,
    input  logic         rst,
    input  logic [W-1:0] electricity,
    input  logic         input_end,
    input  logic         en,
    output logic [3:0]   tube_sel,
    output logic [7:0]   seg,
    output logic         busy
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [W-1:0]     shadow;
    logic             start_pend;
    logic             conv_start;
    logic             conv_busy;
    logic             conv_done;
    logic             conv_ovf;
    logic [BCD_W-1:0] conv_result;
    conv_state_t      conv_state;

    logic [BCD_W-1:0] bcd;
    logic             ovf;
    logic [CW-1:0]    cnt;
    logic [1:0]       idx;
    logic [7:0]       digit_seg;
    logic [3:0]       units;
    logic [3:0]       tens;
    logic [3:0]       hund;

    // A change seen while the converter is busy is simply picked up on the next
    // IDLE cycle, so the most recent value always ends up on the display.
    assign conv_start = (conv_state == IDLE) && (start_pend || (electricity != shadow));

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            shadow     <= '0;
            start_pend <= 1'b1;
        end else if (conv_start) begin
            shadow     <= electricity;
            start_pend <= 1'b0;
        end
    end

    bin2bcd_seq #(.W(W)) u_conv (
        .clkin  (clkin),
        .rst    (rst),
        .start  (conv_start),
        .din    (shadow),
        .busy   (conv_busy),
        .done   (conv_done),
        .result (conv_result),
        .ovf    (conv_ovf),
        .state  (conv_state)
    );

    assign busy = conv_busy;

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            bcd <= '0;
            ovf <= 1'b0;
        end else if (conv_done) begin
            bcd <= conv_result;
            ovf <= conv_ovf;
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign units = bcd[3:0];
    assign tens  = bcd[7:4];
    assign hund  = bcd[11:8];

    always_comb begin
        digit_seg = SEG_BLANK;
        case (idx)
            2'd0: digit_seg = seg_of(units) | {ovf, 7'b0};
            2'd1: if ((hund != 4'd0) || (tens != 4'd0)) digit_seg = seg_of(tens);
            2'd2: if (hund != 4'd0) digit_seg = seg_of(hund);
            default: if (input_end) digit_seg = SEG_E;
        endcase
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            tube_sel <= 4'b0000;
            seg      <= SEG_BLANK;
        end else if (en) begin
            tube_sel <= 4'b0001 << idx;
            seg      <= digit_seg;
        end else begin
            tube_sel <= 4'b0000;
            seg      <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_elec_display.sv
// Bench for elec_display with a fast scan (SCAN_DIV=4): table vectors, hand-written
// corner sequences and randomized values checked against an arithmetic display model.
module tb_elec_display;

    localparam int SCAN_DIV = 4;

    logic       clkin = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] electricity = 10'd0;
    logic       input_end = 1'b0;
    logic       en = 1'b1;
    logic [3:0] tube_sel;
    logic [7:0] seg;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [9:0]  value;
        logic        ie;
        logic [31:0] exp_segs;
    } vec_t;

    vec_t vecs[9];

    elec_display #(.SCAN_DIV(SCAN_DIV), .W(10)) dut (
        .clkin       (clkin),
        .rst         (rst),
        .electricity (electricity),
        .input_end   (input_end),
        .en          (en),
        .tube_sel    (tube_sel),
        .seg         (seg),
        .busy        (busy)
    );

    // clock / reset-relative edge counter
    always #5 clkin = ~clkin;

    always @(posedge clkin or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [7:0] ref_digit(input int d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            default: return 8'h6F;
        endcase
    endfunction

    function automatic logic [31:0] ref_segs(input int v, input logic ie);
        int c;
        logic [7:0] s0, s1, s2, s3;
        c  = (v > 999) ? 999 : v;
        s0 = ref_digit(c % 10) | ((v > 999) ? 8'h80 : 8'h00);
        s1 = (c >= 10) ? ref_digit((c / 10) % 10) : 8'h00;
        s2 = (c >= 100) ? ref_digit(c / 100) : 8'h00;
        s3 = ie ? 8'h79 : 8'h00;
        return {s3, s2, s1, s0};
    endfunction

    function automatic int exp_idx(input int k);
        return ((k - 1) / SCAN_DIV) % 4;
    endfunction

    // driver / checker tasks
    task automatic check_display(input string name, input logic [31:0] exp_segs);
        int i;
        logic [3:0] oh;
        for (int c = 0; c < 16; c++) begin
            @(negedge clkin);
            i  = exp_idx(edge_cnt);
            oh = 4'b0001 << i;
            check({name, "_sel"}, {28'b0, tube_sel}, {28'b0, oh});
            check({name, "_seg"}, {24'b0, seg}, {24'b0, exp_segs[8*i +: 8]});
        end
    endtask

    task automatic apply_and_time(input string name, input logic [9:0] v, input logic ie);
        int highs;
        int last_high;
        highs = 0;
        last_high = 0;
        @(negedge clkin);
        electricity = v;
        input_end = ie;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clkin);
            if (busy) begin
                highs++;
                last_high = c;
            end
        end
        check({name, "_busy_len"}, highs, 12);
        check({name, "_busy_end"}, last_high, 12);
    endtask

    initial begin
        int highs;
        int seen12;
        int hold;
        int v;
        int w;
        logic ie;
        logic [3:0] oh;

        vecs[0] = '{10'd305,  1'b0, 32'h004F3F6D};
        vecs[1] = '{10'd1000, 1'b0, 32'h006F6FEF};
        vecs[2] = '{10'd999,  1'b0, 32'h006F6F6F};
        vecs[3] = '{10'd7,    1'b0, 32'h00000007};
        vecs[4] = '{10'd10,   1'b0, 32'h0000063F};
        vecs[5] = '{10'd100,  1'b1, 32'h79063F3F};
        vecs[6] = '{10'd1023, 1'b1, 32'h796F6FEF};
        vecs[7] = '{10'd58,   1'b1, 32'h79006D7F};
        vecs[8] = '{10'd0,    1'b0, 32'h0000003F};

        // reset state
        repeat (3) @(negedge clkin);
        check("rst_sel", {28'b0, tube_sel}, 32'h0);
        check("rst_seg", {24'b0, seg}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b1;
        check_display("reset_scan", ref_segs(0, 1'b0));

        // table vectors
        for (int n = 0; n < 9; n++) begin
            apply_and_time($sformatf("vec%0d", n), vecs[n].value, vecs[n].ie);
            check_display($sformatf("vec%0d", n), vecs[n].exp_segs);
        end

        // change 12 -> 47 while the 12 conversion is shifting
        highs = 0;
        seen12 = 0;
        @(negedge clkin);
        electricity = 10'd12;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clkin);
            if (busy) highs++;
            if (tube_sel == 4'b0001 && seg == 8'h5B) seen12++;
            if (c == 5) electricity = 10'd47;
        end
        check("midshift_busy_total", highs, 24);
        check("midshift_saw_12", {31'b0, seen12 > 0}, 32'h1);
        check_display("midshift_final", ref_segs(47, 1'b0));

        // display enable
        input_end = 1'b1;
        @(negedge clkin);
        en = 1'b0;
        hold = $urandom_range(3, 9);
        for (int c = 0; c < hold; c++) begin
            @(negedge clkin);
            check("en0_sel", {28'b0, tube_sel}, 32'h0);
            check("en0_seg", {24'b0, seg}, 32'h0);
        end
        en = 1'b1;
        @(negedge clkin);
        oh = 4'b0001 << exp_idx(edge_cnt);
        check("en1_sel", {28'b0, tube_sel}, {28'b0, oh});
        check("en1_seg", {24'b0, seg}, {24'b0, ref_segs(47, 1'b1) >> (8 * exp_idx(edge_cnt))} & 32'hFF);
        check_display("en1_scan", ref_segs(47, 1'b1));

        // randomized values, some changed again mid-conversion
        for (int r = 0; r < 20; r++) begin
            v  = $urandom_range(0, 1023);
            ie = 1'($urandom_range(0, 1));
            @(negedge clkin);
            if ($urandom_range(0, 2) == 0) begin
                w = $urandom_range(0, 1023);
                electricity = 10'(w);
                repeat ($urandom_range(1, 14)) @(negedge clkin);
            end
            electricity = 10'(v);
            input_end = ie;
            exp_q.push_back(ref_segs(v, ie));
            repeat (30) @(negedge clkin);
            check_display($sformatf("rand%0d_v%0d", r, v), exp_q.pop_front());
        end

        // reset in the middle of a conversion
        input_end = 1'b0;
        @(negedge clkin);
        electricity = 10'd555;
        repeat (5) @(negedge clkin);
        #2 rst = 1'b0;
        #1;
        check("midrst_sel", {28'b0, tube_sel}, 32'h0);
        check("midrst_seg", {24'b0, seg}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        @(negedge clkin);
        rst = 1'b1;
        @(negedge clkin);
        check("postrst_sel", {28'b0, tube_sel}, 32'h1);
        check("postrst_seg0", {24'b0, seg}, 32'h3F);
        repeat (12) @(negedge clkin);
        check_display("postrst_555", ref_segs(555, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
